// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core with a single shared memory port (req/ready handshake).
// FSM sequences FETCH/DECODE/EXEC/MEM/WB; illegal or misaligned operations optionally halt the core.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned DEBUG_REG   = 16,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [31:0] retired,
  output logic [31:0] debug_reg
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;
  localparam logic [4:0] DBG_IDX = 5'(DEBUG_REG);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d, retired_q, retired_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, alu_r;
  logic        is_rtype, is_j, is_beq, is_bne, is_addi, is_lw, is_sw, r_legal, legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_j     = (opcode == OP_J);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign legal    = (is_rtype & r_legal) | is_j | is_beq | is_bne | is_addi | is_lw | is_sw;

  // Shifts take their operand from B (rt) and the amount from the shamt field.
  always_comb begin
    r_legal = 1'b1;
    alu_r   = '0;
    case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {31'd0, $signed(a_q) < $signed(b_q)};
      FN_SLL:  alu_r = b_q << shamt;
      FN_SRL:  alu_r = b_q >> shamt;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = pc_q + (imm_sext << 2);
        if (!legal) begin
          state_d = HALT_ON_ERR ? S_HALT : S_FETCH;
        end else if (is_j) begin
          pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_rtype) begin
          alu_out_d = alu_r;
          state_d   = S_WB;
        end else if (is_beq || is_bne) begin
          if ((a_q == b_q) ^ is_bne) pc_d = alu_out_q;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          alu_out_d = a_q + imm_sext;
          state_d   = is_addi ? S_WB : S_MEM;
        end
      end
      S_MEM: begin
        mem_addr  = {alu_out_q[31:2], 2'b00};
        mem_wdata = is_sw ? b_q : '0;
        if (alu_out_q[1:0] != 2'b00) begin
          state_d = HALT_ON_ERR ? S_HALT : S_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = is_sw;
          if (mem_ready) begin
            if (is_lw) begin
              mdr_d   = mem_rdata;
              state_d = S_WB;
            end else begin
              retired_d = retired_q + 32'd1;
              state_d   = S_FETCH;
            end
          end
        end
      end
      S_WB: begin
        rf_waddr  = is_rtype ? rd : rt;
        rf_wdata  = is_lw ? mdr_q : alu_out_q;
        rf_we     = (rf_waddr != 5'd0);
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      default: halted = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign retired   = retired_q;
  assign debug_reg = rf_q[DBG_IDX];

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: single-program vectors from reset plus
// hand-written stall, branch-loop, halt, reset-abort and no-halt sequences.
module tb_multicycle_datapath;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ready = 1'b1;
  logic [31:0] mem [256];

  logic        req, we, halted;
  logic [31:0] addr, wdata, rdata, retired, dbg;
  logic        req2, we2, halted2;
  logic [31:0] addr2, wdata2, rdata2, retired2, dbg2;

  assign rdata  = mem[addr[9:2]];
  assign rdata2 = mem[addr2[9:2]];

  always #5 Clk = ~Clk;

  multicycle_datapath dut (
    .Clk(Clk), .Rst(Rst), .mem_req(req), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .mem_rdata(rdata), .mem_ready(ready), .halted(halted), .retired(retired), .debug_reg(dbg)
  );

  multicycle_datapath #(.RESET_PC(32'h0000_0100), .DEBUG_REG(0), .HALT_ON_ERR(1'b0)) dut_nh (
    .Clk(Clk), .Rst(Rst), .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_rdata(rdata2), .mem_ready(1'b1), .halted(halted2), .retired(retired2), .debug_reg(dbg2)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] p0, p1, p2, data;
    int unsigned cycles;
    logic [31:0] exp_dbg, exp_ret, exp_addr;
    logic        exp_req, exp_halt;
  } vec_t;

  function automatic vec_t mk(string nm, logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                              logic [31:0] d, int unsigned cyc, logic [31:0] edbg,
                              logic [31:0] eret, logic ereq, logic [31:0] eaddr, logic ehalt);
    vec_t v;
    v.name = nm; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.data = d; v.cycles = cyc;
    v.exp_dbg = edbg; v.exp_ret = eret; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_halt = ehalt;
    return v;
  endfunction

  // Clears the dut program area (words 0..63); the dut_nh program at 0x100 is left alone.
  task automatic load(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [31:0] d);
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[32] = d;
  endtask

  vec_t vecs[16];
  logic [31:0] li1, li2, j40;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    mem[65] = enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h20);
    mem[66] = 32'hFC00_0000;

    li1 = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    li2 = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    j40 = {6'h02, 26'h10};
    vecs[0]  = mk("addi", enc_i(6'h08, 5'd0, 5'd16, 16'd5), 0, 0, 0, 4, 32'd5, 1, 1, 32'h4, 0);
    vecs[1]  = mk("add", li1, li2, enc_r(5'd1, 5'd2, 5'd16, 5'd0, 6'h20), 0, 12, 32'd4, 3, 1, 32'hC, 0);
    vecs[2]  = mk("sub", li1, li2, enc_r(5'd1, 5'd2, 5'd16, 5'd0, 6'h22), 0, 12, 32'd10, 3, 1, 32'hC, 0);
    vecs[3]  = mk("and", li1, li2, enc_r(5'd1, 5'd2, 5'd16, 5'd0, 6'h24), 0, 12, 32'd5, 3, 1, 32'hC, 0);
    vecs[4]  = mk("or", li1, li2, enc_r(5'd1, 5'd2, 5'd16, 5'd0, 6'h25), 0, 12, 32'hFFFF_FFFF, 3, 1, 32'hC, 0);
    vecs[5]  = mk("slt", li1, li2, enc_r(5'd2, 5'd1, 5'd16, 5'd0, 6'h2A), 0, 12, 32'd1, 3, 1, 32'hC, 0);
    vecs[6]  = mk("sll", li1, li2, enc_r(5'd0, 5'd2, 5'd16, 5'd4, 6'h00), 0, 12, 32'hFFFF_FFD0, 3, 1, 32'hC, 0);
    vecs[7]  = mk("srl", li1, li2, enc_r(5'd0, 5'd2, 5'd16, 5'd28, 6'h02), 0, 12, 32'hF, 3, 1, 32'hC, 0);
    vecs[8]  = mk("lw", enc_i(6'h23, 5'd0, 5'd16, 16'h0080), 0, 0, 32'h1234_5678, 5, 32'h1234_5678, 1, 1, 32'h4, 0);
    vecs[9]  = mk("j", j40, 0, 0, 0, 2, 32'd0, 1, 1, 32'h40, 0);
    vecs[10] = mk("wrap", enc_i(6'h08, 5'd0, 5'd1, 16'd1), enc_r(5'd0, 5'd1, 5'd1, 5'd31, 6'h00),
                  enc_i(6'h08, 5'd1, 5'd16, 16'hFFFF), 0, 12, 32'h7FFF_FFFF, 3, 1, 32'hC, 0);
    vecs[11] = mk("r0", enc_i(6'h08, 5'd0, 5'd0, 16'd9), enc_r(5'd0, 5'd0, 5'd16, 5'd0, 6'h20), 0, 0,
                  8, 32'd0, 2, 1, 32'h8, 0);
    vecs[12] = mk("ill_op", 32'hFC00_0000, 0, 0, 0, 2, 32'd0, 0, 0, 32'h0, 1);
    vecs[13] = mk("ill_fn", enc_r(5'd0, 5'd0, 5'd16, 5'd0, 6'h3F), 0, 0, 0, 2, 32'd0, 0, 0, 32'h0, 1);
    vecs[14] = mk("beq_tk", enc_i(6'h04, 5'd0, 5'd0, 16'd1), 0, 0, 0, 3, 32'd0, 1, 1, 32'h8, 0);
    vecs[15] = mk("bne_nt", enc_i(6'h05, 5'd0, 5'd0, 16'd1), 0, 0, 0, 3, 32'd0, 1, 1, 32'h4, 0);

    // Reset state
    tick();
    Rst = 1'b0;
    check("rst_req", {31'd0, req}, 32'd1);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_nh_addr", addr2, 32'h100);

    foreach (vecs[k]) begin
      Rst = 1'b1; ready = 1'b1;
      load(vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].data);
      tick();
      Rst = 1'b0;
      repeat (vecs[k].cycles) tick();
      check({vecs[k].name, "_dbg"}, dbg, vecs[k].exp_dbg);
      check({vecs[k].name, "_ret"}, retired, vecs[k].exp_ret);
      check({vecs[k].name, "_req"}, {31'd0, req}, {31'd0, vecs[k].exp_req});
      check({vecs[k].name, "_halt"}, {31'd0, halted}, {31'd0, vecs[k].exp_halt});
      if (vecs[k].exp_req) check({vecs[k].name, "_addr"}, addr, vecs[k].exp_addr);
    end

    // lw with three stall cycles in MEM: eight cycles total
    Rst = 1'b1; ready = 1'b1;
    load(enc_i(6'h23, 5'd0, 5'd16, 16'h0008), 0, 32'hDEAD_BEEF, 0);
    tick(); Rst = 1'b0;
    repeat (3) tick();
    check("lws_mreq", {31'd0, req}, 32'd1);
    check("lws_maddr", addr, 32'h8);
    check("lws_mwe", {31'd0, we}, 32'd0);
    ready = 1'b0;
    repeat (3) tick();
    check("lws_hold_addr", addr, 32'h8);
    check("lws_hold_req", {31'd0, req}, 32'd1);
    check("lws_hold_ret", retired, 32'd0);
    ready = 1'b1;
    repeat (2) tick();
    check("lws_dbg", dbg, 32'hDEAD_BEEF);
    check("lws_ret", retired, 32'd1);
    check("lws_next", addr, 32'h4);

    // beq self-loop at 0x40, then bne falls through
    Rst = 1'b1;
    load(j40, 0, 0, 0);
    mem[16] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    tick(); Rst = 1'b0;
    repeat (2) tick();
    check("loop_j_addr", addr, 32'h40);
    for (int n = 0; n < 2; n++) begin
      repeat (3) tick();
      check("loop_beq_addr", addr, 32'h40);
      check("loop_beq_ret", retired, 32'(2 + n));
    end
    mem[16] = enc_i(6'h05, 5'd0, 5'd0, 16'hFFFF);
    repeat (3) tick();
    check("loop_bne_addr", addr, 32'h44);
    check("loop_bne_ret", retired, 32'd4);

    // sw of 0x7FFFFFFF+1, then misaligned lw halts the core
    Rst = 1'b1;
    load(enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF), enc_r(5'd0, 5'd1, 5'd1, 5'd1, 6'h02),
         enc_i(6'h08, 5'd1, 5'd1, 16'd1), 0);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0080);
    mem[4] = enc_i(6'h23, 5'd0, 5'd2, 16'h0002);
    tick(); Rst = 1'b0;
    repeat (15) tick();
    check("sw_req", {31'd0, req}, 32'd1);
    check("sw_we", {31'd0, we}, 32'd1);
    check("sw_addr", addr, 32'h80);
    check("sw_wdata", wdata, 32'h8000_0000);
    tick();
    check("sw_ret", retired, 32'd4);
    check("sw_next", addr, 32'h10);
    repeat (3) tick();
    check("mis_noreq", {31'd0, req}, 32'd0);
    tick();
    check("mis_halted", {31'd0, halted}, 32'd1);
    repeat (3) tick();
    check("halt_req", {31'd0, req}, 32'd0);
    check("halt_stay", {31'd0, halted}, 32'd1);
    check("halt_ret", retired, 32'd4);

    // Reset on the same edge as a completing FETCH handshake
    Rst = 1'b1;
    load(j40, 0, 0, 0);
    mem[16] = enc_i(6'h08, 5'd0, 5'd16, 16'd3);
    tick(); Rst = 1'b0;
    repeat (2) tick();
    check("abort_pre_addr", addr, 32'h40);
    ready = 1'b0;
    tick();
    check("abort_stall_req", {31'd0, req}, 32'd1);
    Rst = 1'b1; ready = 1'b1;
    tick();
    Rst = 1'b0;
    check("abort_req", {31'd0, req}, 32'd1);
    check("abort_addr", addr, 32'h0);
    check("abort_ret", retired, 32'd0);
    repeat (2) tick();
    check("abort_dbg", dbg, 32'd0);

    // add $0,$1,$1 then illegal opcode, with and without halt-on-error
    Rst = 1'b1;
    load(enc_i(6'h08, 5'd0, 5'd1, 16'd3), enc_r(5'd1, 5'd1, 5'd0, 5'd0, 6'h20), 32'hFC00_0000, 0);
    tick(); Rst = 1'b0;
    repeat (8) tick();
    check("ill_ret", retired, 32'd2);
    check("nh_r0", dbg2, 32'd0);
    check("nh_ret", retired2, 32'd2);
    repeat (2) tick();
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_noreq", {31'd0, req}, 32'd0);
    check("nh_halted", {31'd0, halted2}, 32'd0);
    check("nh_req", {31'd0, req2}, 32'd1);
    check("nh_we", {31'd0, we2}, 32'd0);
    check("nh_addr", addr2, 32'h10C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
